// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - requester/multiplier handshake bundle for booth_mult_seq
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 ack;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier, ack,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier, ack,
    output ready, busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, one iteration per cycle
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 2);
  // A holds N+1 bits for the worst case (unsigned, N=WIDTH+1); Q holds the widest extended multiplier.
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        m_q, m_d;
  logic [QW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [AW-1:0]        a_sum;
  logic [AW+QW:0]       shift_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    product_d = product_q;

    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    shift_v = {a_sum[AW-1], a_sum, q_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sgn_d = bus.signed_mode;
          a_d   = '0;
          qm1_d = 1'b0;
          if (bus.signed_mode) begin
            m_d   = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            q_d   = {bus.multiplier[WIDTH-1], bus.multiplier};
            cnt_d = CNT_W'(WIDTH);
          end else begin
            m_d   = {2'b00, bus.multiplicand};
            q_d   = {1'b0, bus.multiplier};
            cnt_d = CNT_W'(WIDTH + 1);
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = shift_v[AW+QW:QW+1];
        q_d   = shift_v[QW:1];
        qm1_d = shift_v[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Signed runs one iteration fewer, so the unexamined sign bit still sits at Q[0].
          product_d = sgn_q ? shift_v[2*WIDTH+1:2] : shift_v[2*WIDTH:1];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule
